// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MIPS load/store unit.
// Size codes, FSM states and the default memory word-address width.
package mips_lsu_pkg;

    localparam int ADDR_W_DEF = 10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_e;

endpackage

// File: rtl/mips_lsu_align.sv
// Big-endian lane logic: load extract/extend, store-lane merge,
// and misalignment detection (byte offset 0 = bits 31:24).
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ldata_o,
    output logic [31:0] merged_o,
    output logic        misalign_o
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [31:0] bsel;
    logic [31:0] hsel;

    // Lane shift counts: byte (3-off)*8, half (2-off)*8
    assign bsh  = {~off_i, 3'b000};
    assign hsh  = {~off_i[1], 4'b0000};
    assign bsel = word_i >> bsh;
    assign hsel = word_i >> hsh;

    always_comb begin
        ldata_o    = word_i;
        merged_o   = wdata_i;
        misalign_o = 1'b0;
        unique case (size_i)
            SZ_BYTE: begin
                ldata_o  = {{24{~unsigned_i & bsel[7]}}, bsel[7:0]};
                merged_o = (word_i & ~(32'h0000_00FF << bsh))
                         | ({24'b0, wdata_i[7:0]} << bsh);
            end
            SZ_HALF: begin
                ldata_o    = {{16{~unsigned_i & hsel[15]}}, hsel[15:0]};
                merged_o   = (word_i & ~(32'h0000_FFFF << hsh))
                           | ({16'b0, wdata_i[15:0]} << hsh);
                misalign_o = off_i[0];
            end
            SZ_WORD: begin
                misalign_o = |off_i;
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: byte-addressed requests to a word memory, RMW for sb/sh.
// Optional single-word buffer enabled by MIPS_LSU_WORD_BUF_EN.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              misalign,
    output logic              mem_rd_wr,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] mem_entrada,
    input  logic [DATA_W-1:0] mem_saida
);

    state_e            state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       wr_q;
    logic [31:0]       rdata_q;
    logic              mis_q;

    logic        acc;
    logic        idle;
    logic [1:0]  al_size;
    logic        al_uns;
    logic [1:0]  al_off;
    logic [31:0] al_word;
    logic [31:0] al_wdata;
    logic [31:0] al_ldata;
    logic [31:0] al_merged;
    logic        al_mis;
    logic        hit;
    logic        unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];
    assign idle        = (state_q == S_IDLE);
    assign acc         = req_valid & idle;

`ifdef MIPS_LSU_WORD_BUF_EN
    logic              bv_q;
    logic [ADDR_W-1:0] ba_q;
    logic [31:0]       bd_q;

    assign hit     = bv_q & (ba_q == req_addr[ADDR_W+1:2]);
    assign al_word = idle ? bd_q : mem_saida;
`else
    assign hit     = 1'b0;
    assign al_word = mem_saida;
`endif

    // In IDLE the aligner screens the incoming request; later, the latched one
    assign al_size  = idle ? req_size : size_q;
    assign al_uns   = idle ? req_unsigned : uns_q;
    assign al_off   = idle ? req_addr[1:0] : off_q;
    assign al_wdata = idle ? req_wdata : wdata_q;

    mips_lsu_align u_align (
        .size_i     (al_size),
        .unsigned_i (al_uns),
        .off_i      (al_off),
        .word_i     (al_word),
        .wdata_i    (al_wdata),
        .ldata_o    (al_ldata),
        .merged_o   (al_merged),
        .misalign_o (al_mis)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    if (al_mis)
                        state_d = S_DONE;
                    else if (hit && !req_we)
                        state_d = S_DONE;
                    else if (req_we && (hit || req_size == SZ_WORD))
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = we_q ? S_WR : S_DONE;
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wdata_q <= '0;
            wr_q    <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                off_q   <= req_addr[1:0];
                waddr_q <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
                rdata_q <= '0;
                mis_q   <= al_mis;
                if (req_we)
                    wr_q <= (hit && !al_mis) ? al_merged : req_wdata;
                else if (hit && !al_mis)
                    rdata_q <= al_ldata;
            end
            if (state_q == S_CAP) begin
                if (we_q)
                    wr_q <= al_merged;
                else
                    rdata_q <= al_ldata;
            end
        end
    end

`ifdef MIPS_LSU_WORD_BUF_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bv_q <= 1'b0;
            ba_q <= '0;
            bd_q <= '0;
        end else if (state_q == S_CAP) begin
            bv_q <= 1'b1;
            ba_q <= waddr_q;
            bd_q <= mem_saida;
        end else if (state_q == S_WR) begin
            bv_q <= 1'b1;
            ba_q <= waddr_q;
            bd_q <= wr_q;
        end
    end
`endif

    assign req_ready    = idle;
    assign resp_valid   = (state_q == S_DONE);
    assign resp_rdata   = rdata_q;
    assign misalign     = mis_q;
    assign mem_rd_wr    = (state_q == S_WR);
    assign mem_endereco = waddr_q;
    assign mem_entrada  = wr_q;

endmodule
